// File: rtl/pipeline_run_controller.sv
// -----------------------------------------------------------------------------
// pipeline_run_controller
//
// Run/step/pause sequencer for the MIPS pipeline debug path. Drives the global
// pipe_enable that gates the pipeline registers and the control unit. Once the
// HALT opcode reaches ID the pipeline is allowed to drain for a fixed number of
// enabled cycles and is then frozen until reset. Enabled cycles are counted for
// readout.
//
// Parameters:
//   HALT_OPCODE   opcode in ID that terminates the program
//   DRAIN_CYCLES  enabled cycles after HALT is decoded (1..15)
//   CNT_W         width of cycle_count
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   cmd_valid    debug command present
//   cmd_code     00 NOP, 01 RUN, 10 STEP, 11 PAUSE
//   cmd_ready    command can be accepted this cycle
//   op_code      opcode of the instruction currently in ID
//   pipe_enable  pipeline / control-unit enable
//   running      high in RUN or DRAIN
//   halted       program finished (DONE)
//   step_done    one-cycle pulse in the first IDLE cycle after a step
//   cycle_count  saturating count of cycles with pipe_enable high
// -----------------------------------------------------------------------------
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | pipeline frozen, waiting for RUN or STEP
//   RUN     | free running until PAUSE or HALT decode
//   STEP    | single enabled cycle, then back to IDLE
//   DRAIN   | HALT decoded, letting in-flight instructions retire
//   DONE    | program finished, frozen until reset
//
module pipeline_run_controller #(
   parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_code,
   output logic             cmd_ready,
   input  logic [5:0]       op_code,
   output logic             pipe_enable,
   output logic             running,
   output logic             halted,
   output logic             step_done,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_PAUSE = 2'b11;

   // Drain timer counts down from DRAIN_CYCLES-1 so the terminal count (0)
   // lands on the last enabled drain cycle.
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] drain_cnt;
   logic [3:0] drain_cnt_nxt;
   logic       cmd_accept;
   logic       halt_hit;
   logic       drain_tc;

   // Moore outputs, decoded from the state register only.
   assign pipe_enable = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
   assign running     = (state == S_RUN) || (state == S_DRAIN);
   assign halted      = (state == S_DONE);
   assign cmd_ready   = (state == S_IDLE) || (state == S_RUN);

   assign cmd_accept = cmd_valid && cmd_ready;
   // The opcode in ID is only meaningful while the pipeline is advancing.
   assign halt_hit   = pipe_enable && (op_code == HALT_OPCODE);
   assign drain_tc   = (drain_cnt == 4'd0);

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      case (state)
         S_IDLE: begin
            if (cmd_accept) begin
               case (cmd_code)
                  CMD_RUN:   state_nxt = S_RUN;
                  CMD_STEP:  state_nxt = S_STEP;
                  CMD_PAUSE: state_nxt = S_IDLE;
                  CMD_NOP:   state_nxt = S_IDLE;
                  default:   state_nxt = S_IDLE;
               endcase
            end
         end
         S_RUN: begin
            // HALT outranks a PAUSE in the same cycle; the PAUSE is still
            // handshaken (cmd_ready is high) and simply dropped.
            if (halt_hit) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end else if (cmd_accept && (cmd_code == CMD_PAUSE)) begin
               state_nxt = S_IDLE;
            end
         end
         S_STEP: begin
            if (halt_hit) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (drain_tc) begin
               state_nxt = S_DONE;
            end else begin
               drain_cnt_nxt = drain_cnt - 4'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         drain_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // A step that hits HALT goes to DRAIN and never reports completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_done <= 1'b0;
      end else begin
         step_done <= (state == S_STEP) && !halt_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count <= '0;
      end else if (pipe_enable && (cycle_count != CNT_MAX)) begin
         cycle_count <= cycle_count + CNT_ONE;
      end
   end

endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Sequences execution of the MIPS pipeline for the debug path. Accepts run, step and pause commands from the debug front end and drives the global `pipe_enable` that gates the pipeline registers and the control unit's `enable`. Watches the opcode decoded in ID and, on the HALT opcode, lets the pipeline drain for a fixed number of cycles before freezing it. Keeps a count of executed (enabled) cycles for readout.

## Interface
- `HALT_OPCODE`, default 6'b111111: opcode that terminates the program.
- `DRAIN_CYCLES`, default 4: enabled cycles after HALT is decoded; range 1..15.
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_code`  in  2  00 NOP, 01 RUN, 10 STEP, 11 PAUSE.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `op_code`  in  6  opcode of the instruction currently in ID.
- `pipe_enable`  out  1  pipeline/control-unit enable.
- `running`  out  1  high in RUN or DRAIN.
- `halted`  out  1  program finished (DONE state).
- `step_done`  out  1  one-cycle pulse after a completed step.
- `cycle_count`  out  CNT_W  number of cycles with `pipe_enable`=1.

## Operation
- States: IDLE, RUN, STEP, DRAIN, DONE. Reset → IDLE.
- Command accepted when `cmd_valid && cmd_ready`. `cmd_ready`=1 in IDLE and RUN, 0 in STEP, DRAIN and DONE. NOP is accepted with no effect.
- IDLE: `pipe_enable`=0. RUN → RUN. STEP → STEP. PAUSE → stays IDLE.
- RUN: `pipe_enable`=1.
  - `op_code`==HALT_OPCODE → DRAIN.
  - Otherwise PAUSE → IDLE.
  - RUN and STEP are accepted and ignored.
- STEP: `pipe_enable`=1 for exactly one cycle.
  - If `op_code`==HALT_OPCODE in that cycle → DRAIN.
  - Else → IDLE, with `step_done`=1 in the first IDLE cycle.
- DRAIN: `pipe_enable`=1.
  - 4-bit drain counter loaded with DRAIN_CYCLES-1 on entry, decremented each cycle.
  - At 0 → DONE. Commands are not accepted.
- DONE: `pipe_enable`=0, `halted`=1. Only `reset` leaves DONE.
- HALT detection is evaluated only while `pipe_enable`=1. In IDLE the opcode is ignored.
- Simultaneous events: HALT opcode in RUN plus PAUSE in the same cycle → DRAIN wins. The PAUSE is still handshaken (`cmd_ready`=1) and discarded.
- `cycle_count`:
  - Increments by 1 at the end of every cycle with `pipe_enable`=1.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset.
- Reset values: state IDLE, `pipe_enable`=0, `running`=0, `halted`=0, `step_done`=0, `cycle_count`=0, `cmd_ready`=1. Reset mid-RUN or mid-DRAIN aborts immediately; the next cycle is IDLE.

## Timing
- Moore outputs: `pipe_enable`, `running`, `halted` and `cmd_ready` are decoded from the state register only. `step_done` is a registered pulse.
- Command accepted at edge N → new state, and `pipe_enable`, from cycle N+1.
- RUN/STEP to `pipe_enable` latency: 1 cycle.
- PAUSE accepted at edge N → `pipe_enable`=0 from cycle N+1.
- STEP: exactly 1 enabled cycle; `step_done` high in the following cycle only.
- HALT seen in cycle K (enabled) → DRAIN during cycles K+1..K+DRAIN_CYCLES → DONE from cycle K+DRAIN_CYCLES+1. The HALT cycle itself counts in `cycle_count`.
- Total enabled cycles from RUN until the HALT decode at K is K−start+1; DRAIN adds DRAIN_CYCLES.

## Test plan
- **Reset, then idle:** reset 2 cycles, idle 5 cycles → `pipe_enable`=0, `cmd_ready`=1, `cycle_count`=0, `halted`=0 throughout.
- **Run then pause:** RUN at cycle 0, PAUSE accepted at cycle 10 → `pipe_enable`=1 for cycles 1..10, 0 from 11; `cycle_count`=10.
- **Three steps:** 3 STEP commands spaced 4 cycles apart → each gives one `pipe_enable` pulse and one `step_done` pulse the following cycle; `cycle_count`=3.
- **Run to HALT:** RUN, drive `op_code`=6'b111111 on the 7th enabled cycle, DRAIN_CYCLES=4 → 4 more enabled cycles, then `halted`=1, `pipe_enable`=0, `cycle_count`=11. A later RUN is not accepted (`cmd_ready`=0).
- **HALT with simultaneous PAUSE:** HALT opcode and PAUSE in the same RUN cycle → DRAIN entered, full 4-cycle drain, DONE.
- **Reset and saturation:**
  - Reset asserted mid-DRAIN → IDLE next cycle, all outputs at reset values.
  - With CNT_W=4, 20 enabled cycles → `cycle_count` holds at 15.
